serial_subtractor: RTL and testbench



---
 rtl/serial_subtractor.sv | 116 +++++++++++
 tb/tb_serial_subtractor.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: diff = a - b - bin over WIDTH cycles, LSB first,
// using a single full-subtractor cell and a borrow flip-flop, framed by start/busy/done.
module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int unsigned CW = ($clog2(WIDTH + 1) < 1) ? 1 : $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] sd;
  logic [WIDTH-1:0] sd_nxt;
  logic [CW-1:0]    cnt;
  logic             br;
  logic             br_nxt;
  logic             d;
  logic             last;
  logic             busy_nxt;
  logic             done_nxt;

  // Full-subtractor cell on the current LSBs plus the stored borrow.
  assign d      = sa[0] ^ sb[0] ^ br;
  assign br_nxt = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br);
  assign sd_nxt = (sd >> 1) | (WIDTH'(d) << (WIDTH - 1));
  assign last   = (cnt == CW'(WIDTH - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; start is only looked at in IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (last)  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake outputs are decoded from the next state so they register alongside it.
  always_comb begin
    busy_nxt = 1'b0;
    done_nxt = 1'b0;
    if (state_nxt != IDLE) busy_nxt = 1'b1;
    if (state_nxt == DONE) done_nxt = 1'b1;
  end

  // Datapath and output registers; diff/bout only move on the final shift edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sa   <= '0;
      sb   <= '0;
      sd   <= '0;
      br   <= 1'b0;
      cnt  <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      diff <= '0;
      bout <= 1'b0;
    end else begin
      busy <= busy_nxt;
      done <= done_nxt;
      case (state)
        IDLE: begin
          if (start) begin
            sa  <= a;
            sb  <= b;
            br  <= bin;
            sd  <= '0;
            cnt <= '0;
          end
        end
        SHIFT: begin
          sa  <= sa >> 1;
          sb  <= sb >> 1;
          sd  <= sd_nxt;
          br  <= br_nxt;
          cnt <= cnt + CW'(1);
          if (last) begin
            diff <= sd_nxt;
            bout <= br_nxt;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: scoreboarded directed cases at WIDTH=8
// and an exhaustive sweep at WIDTH=4.
module tb_serial_subtractor;

  logic       clk;
  logic       rst_n;
  logic       start8, bin8, busy8, done8, bout8;
  logic [7:0] a8, b8, diff8;
  logic       start4, bin4, busy4, done4, bout4;
  logic [3:0] a4, b4, diff4;

  int n_checks = 0;
  int n_errors = 0;
  int done_cnt8 = 0;
  int done_cnt4 = 0;
  logic [8:0] q8[$];
  logic [4:0] q4[$];

  serial_subtractor #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .bin(bin8),
    .busy(busy8), .done(done8), .diff(diff8), .bout(bout8)
  );

  serial_subtractor #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .bin(bin4),
    .busy(busy4), .done(done4), .diff(diff4), .bout(bout4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference model for a WIDTH-bit subtract: {diff, bout}.
  function automatic logic [8:0] model8(input int ta, input int tb, input int tbin);
    int r;
    r = (ta - tb - tbin) & 255;
    return {8'(r), 1'(ta < tb + tbin)};
  endfunction

  function automatic logic [4:0] model4(input int ta, input int tb, input int tbin);
    int r;
    r = (ta - tb - tbin) & 15;
    return {4'(r), 1'(ta < tb + tbin)};
  endfunction

  // Scoreboard monitors: pop the expected result whenever done pulses.
  always @(negedge clk) begin
    logic [8:0] e;
    if (done8) begin
      done_cnt8++;
      if (q8.size() == 0) begin
        check("spurious_done8", 1, 0);
      end else begin
        e = q8.pop_front();
        check("diff8", diff8, e[8:1]);
        check("bout8", bout8, e[0]);
      end
    end
  end

  always @(negedge clk) begin
    logic [4:0] e;
    if (done4) begin
      done_cnt4++;
      if (q4.size() == 0) begin
        check("spurious_done4", 1, 0);
      end else begin
        e = q4.pop_front();
        check("diff4", diff4, e[4:1]);
        check("bout4", bout4, e[0]);
      end
    end
  end

  // One WIDTH=8 operation with latency and busy-length checks.
  task automatic do_op(input logic [7:0] ta, input logic [7:0] tb, input logic tbin);
    int busy_c;
    int lat;
    @(negedge clk);
    a8 = ta; b8 = tb; bin8 = tbin; start8 = 1'b1;
    q8.push_back(model8(int'(ta), int'(tb), int'(tbin)));
    @(posedge clk);
    #1 start8 = 1'b0;
    busy_c = 0;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      if (busy8) busy_c++;
      @(posedge clk);
      #1;
      if (done8) begin
        lat = k;
        break;
      end
    end
    if (lat == 0) begin
      check("timeout8", 0, 1);
    end else begin
      if (busy8) busy_c++;
      check("latency8", lat, 8);
      check("busy_len8", busy_c, 9);
      @(posedge clk);
      #1;
      check("idle_busy8", busy8, 0);
      check("idle_done8", done8, 0);
    end
  endtask

  initial begin
    int dones [$];
    int base;
    int got;
    rst_n = 1'b0;
    start8 = 1'b1; a8 = 8'h12; b8 = 8'h34; bin8 = 1'b0;
    start4 = 1'b0; a4 = '0; b4 = '0; bin4 = 1'b0;

    // Reset, with start asserted: reset must win.
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy8", busy8, 0);
    check("rst_done8", done8, 0);
    check("rst_diff8", diff8, 0);
    check("rst_bout8", bout8, 0);
    check("rst_busy4", busy4, 0);
    @(negedge clk);
    start8 = 1'b0;
    rst_n = 1'b1;

    // Directed operations.
    do_op(8'h05, 8'h03, 1'b0);
    do_op(8'h03, 8'h05, 1'b0);
    do_op(8'h00, 8'h00, 1'b1);
    do_op(8'hFF, 8'hFF, 1'b1);

    // Input changes and a start pulse during SHIFT are ignored.
    base = done_cnt8;
    @(negedge clk);
    a8 = 8'h10; b8 = 8'h01; bin8 = 1'b0; start8 = 1'b1;
    q8.push_back(model8(16, 1, 0));
    @(negedge clk);
    start8 = 1'b0;
    repeat (2) @(negedge clk);
    a8 = 8'hAA; b8 = 8'h55; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (20) @(negedge clk);
    check("ignored_start_dones", done_cnt8 - base, 1);
    check("ignored_start_q", q8.size(), 0);

    // Start held high for 30 edges: one operation every 10 cycles.
    @(negedge clk);
    a8 = 8'h80; b8 = 8'h01; bin8 = 1'b0; start8 = 1'b1;
    repeat (3) q8.push_back(model8(128, 1, 0));
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      if (done8) dones.push_back(i);
      else if (dones.size() > 0) check("hold_diff8", diff8, 8'h7F);
    end
    start8 = 1'b0;
    check("held_pulses", dones.size(), 3);
    if (dones.size() == 3) begin
      check("held_first", dones[0], 8);
      check("held_gap1", dones[1] - dones[0], 10);
      check("held_gap2", dones[2] - dones[1], 10);
    end
    repeat (12) @(negedge clk);
    check("held_q", q8.size(), 0);

    // Reset four cycles into an operation aborts it.
    base = done_cnt8;
    @(negedge clk);
    a8 = 8'h33; b8 = 8'h11; bin8 = 1'b0; start8 = 1'b1;
    @(posedge clk);
    #1 start8 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    check("abort_busy8", busy8, 0);
    check("abort_done8", done8, 0);
    check("abort_diff8", diff8, 0);
    check("abort_bout8", bout8, 0);
    repeat (12) @(negedge clk);
    check("abort_no_done", done_cnt8 - base, 0);
    do_op(8'h33, 8'h11, 1'b0);

    // Exhaustive sweep at WIDTH=4.
    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        for (int ic = 0; ic < 2; ic++) begin
          @(negedge clk);
          a4 = 4'(ia); b4 = 4'(ib); bin4 = 1'(ic); start4 = 1'b1;
          q4.push_back(model4(ia, ib, ic));
          @(negedge clk);
          start4 = 1'b0;
          got = 0;
          for (int k = 0; k < 12; k++) begin
            if (done4) begin
              got = 1;
              break;
            end
            @(negedge clk);
          end
          if (got == 0) check("timeout4", 0, 1);
        end
      end
    end
    repeat (4) @(negedge clk);
    check("sweep_dones4", done_cnt4, 512);
    check("sweep_q4", q4.size(), 0);
    check("final_q8", q8.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
